// File: rtl/ibex_iter_muldiv.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle over a fixed
// IDLE -> ABS -> CALC(32) -> FIX -> DONE schedule, result strobed on valid_o.
module ibex_iter_muldiv #(
   parameter bit EarlyDivZero = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [1:0]  operator_i,
   input  logic [1:0]  signed_mode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [2:0] {IDLE, ABS, CALC, FIX, DONE} state_e;

   state_e      state_q, state_d;
   md_op_e      op_q, op_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] abs_a_q, abs_a_d, abs_b_q, abs_b_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [31:0] result_q, result_d;

   logic        is_mul, div_zero, sa, sb;
   logic [32:0] rem_sh, trial;
   logic [63:0] prod;
   logic [31:0] quot, rem, zero_res;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mode_d   = mode_q;
      a_d      = a_q;
      b_d      = b_q;
      abs_a_d  = abs_a_q;
      abs_b_d  = abs_b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;

      is_mul   = ~op_q[1];
      div_zero = ~is_mul && (b_q == 32'h0);
      // Division treats the operands as signed only when both are marked signed
      sa       = (is_mul ? mode_q[0] : (mode_q == 2'b11)) & a_q[31];
      sb       = (is_mul ? mode_q[1] : (mode_q == 2'b11)) & b_q[31];
      zero_res = (op_q == MD_OP_DIV) ? 32'hFFFF_FFFF : a_q;

      rem_sh   = {acc_q[31:0], abs_a_q[31]};
      trial    = rem_sh - {1'b0, abs_b_q};
      prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot     = (sign_a_q ^ sign_b_q) ? -abs_a_q : abs_a_q;
      rem      = sign_a_q ? -acc_q[31:0] : acc_q[31:0];

      ready_o  = (state_q == IDLE);
      valid_o  = (state_q == DONE);

      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               op_d    = md_op_e'(operator_i);
               mode_d  = signed_mode_i;
               a_d     = op_a_i;
               b_d     = op_b_i;
               state_d = ABS;
            end
         end
         ABS: begin
            sign_a_d = sa;
            sign_b_d = sb;
            abs_a_d  = sa ? -a_q : a_q;
            abs_b_d  = sb ? -b_q : b_q;
            acc_d    = 64'h0;
            cnt_d    = 5'd0;
            if (div_zero && EarlyDivZero) begin
               result_d = zero_res;
               state_d  = DONE;
            end else begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (is_mul) begin
               acc_d = acc_q + (abs_b_q[cnt_q] ? ({32'h0, abs_a_q} << cnt_q) : 64'h0);
            end else begin
               // abs_a_q shifts dividend bits out and quotient bits in
               abs_a_d = {abs_a_q[30:0], ~trial[32]};
               acc_d   = {32'h0, trial[32] ? rem_sh[31:0] : trial[31:0]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            unique case (op_q)
               MD_OP_MULL: result_d = prod[31:0];
               MD_OP_MULH: result_d = prod[63:32];
               MD_OP_DIV:  result_d = div_zero ? zero_res : quot;
               MD_OP_REM:  result_d = div_zero ? zero_res : rem;
               default:    result_d = result_q;
            endcase
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (kill_i && (state_q != IDLE)) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         op_q     <= MD_OP_MULL;
         mode_q   <= 2'b00;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         abs_a_q  <= 32'h0;
         abs_b_q  <= 32'h0;
         acc_q    <= 64'h0;
         cnt_q    <= 5'd0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mode_q   <= mode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         abs_a_q  <= abs_a_d;
         abs_b_q  <= abs_b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_ibex_iter_muldiv.sv
// Directed bench for ibex_iter_muldiv: one EarlyDivZero=1 and one EarlyDivZero=0
// instance sharing operand inputs, each with its own request line.
module tb_ibex_iter_muldiv;

   localparam logic [1:0] MULL = 2'd0, MULH = 2'd1, DIV = 2'd2, REM = 2'd3;

   logic        clk = 1'b0;
   logic        rst, req0, req1, kill;
   logic [1:0]  op, mode;
   logic [31:0] a, b;
   logic        rdy0, vld0, rdy1, vld1;
   logic [31:0] res0, res1;
   int          errs = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   ibex_iter_muldiv #(.EarlyDivZero(1'b1)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .operator_i(op), .signed_mode_i(mode),
      .op_a_i(a), .op_b_i(b), .kill_i(kill), .ready_o(rdy0), .valid_o(vld0), .result_o(res0));

   ibex_iter_muldiv #(.EarlyDivZero(1'b0)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .operator_i(op), .signed_mode_i(mode),
      .op_a_i(a), .op_b_i(b), .kill_i(kill), .ready_o(rdy1), .valid_o(vld1), .result_o(res1));

   // Issues one request, scrambles the inputs after the accept and returns the
   // cycle (relative to the accepting edge) in which valid_o was seen, 0 if none.
   task automatic run_op(input bit which, input logic [1:0] o, input logic [1:0] m,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int vc, output bit rdy_bad,
                         output bit rdy_issue);
      @(negedge clk);
      op = o; mode = m; a = x; b = y;
      rdy_issue = which ? rdy1 : rdy0;
      if (which) req1 = 1'b1; else req0 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~o; mode = ~m;
      vc = 0; rdy_bad = 1'b0; r = 32'h0;
      for (int c = 1; c <= 45 && vc == 0; c++) begin
         @(negedge clk);
         if (which ? rdy1 : rdy0) rdy_bad = 1'b1;
         if (which ? vld1 : vld0) begin
            vc = c;
            r  = which ? res1 : res0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; kill = 1'b0;
      op = 2'd0; mode = 2'd0; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL reset_ready0: got %b expected 1", rdy0); end
      checks++; if (vld0 !== 1'b0) begin errs++; $display("FAIL reset_valid0: got %b expected 0", vld0); end
      checks++; if (res0 !== 32'h0) begin errs++; $display("FAIL reset_result0: got %h expected 00000000", res0); end
      checks++; if (rdy1 !== 1'b1 || vld1 !== 1'b0 || res1 !== 32'h0) begin
         errs++; $display("FAIL reset_dut1: got rdy=%b vld=%b res=%h expected 1 0 00000000", rdy1, vld1, res1); end
   endtask

   task automatic test_mull();
      logic [31:0] r; int vc; bit rb, ri;
      run_op(1'b0, MULL, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, r, vc, rb, ri);
      checks++; if (r !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mull_result: got %h expected ffffffeb", r); end
      checks++; if (vc !== 35) begin errs++; $display("FAIL mull_latency: got %0d expected 35", vc); end
      checks++; if (rb !== 1'b0) begin errs++; $display("FAIL mull_ready_busy: got %b expected 0", rb); end
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
         errs++; $display("FAIL mull_after_done: got rdy=%b vld=%b expected 1 0", rdy0, vld0); end
      checks++; if (res0 !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mull_hold: got %h expected ffffffeb", res0); end
   endtask

   task automatic test_mulh();
      logic [31:0] r; int vc; bit rb, ri;
      run_op(1'b0, MULH, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, vc, rb, ri);
      checks++; if (r !== 32'h0000_0000) begin errs++; $display("FAIL mulh_ss: got %h expected 00000000", r); end
      run_op(1'b0, MULH, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, vc, rb, ri);
      checks++; if (r !== 32'h7FFF_FFFF) begin errs++; $display("FAIL mulh_uu: got %h expected 7fffffff", r); end
      run_op(1'b0, MULH, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, r, vc, rb, ri);
      checks++; if (r !== 32'h8000_0000) begin errs++; $display("FAIL mulh_su: got %h expected 80000000", r); end
   endtask

   task automatic test_div();
      logic [31:0] r; int vc; bit rb, ri;
      run_op(1'b0, DIV, 2'b11, 32'hFFFF_FFF9, 32'h2, r, vc, rb, ri);
      checks++; if (r !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_signed: got %h expected fffffffd", r); end
      checks++; if (vc !== 35) begin errs++; $display("FAIL div_latency: got %0d expected 35", vc); end
      run_op(1'b0, REM, 2'b11, 32'hFFFF_FFF9, 32'h2, r, vc, rb, ri);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rem_signed: got %h expected ffffffff", r); end
      run_op(1'b0, DIV, 2'b00, 32'd100, 32'd7, r, vc, rb, ri);
      checks++; if (r !== 32'd14) begin errs++; $display("FAIL div_unsigned: got %h expected 0000000e", r); end
      run_op(1'b0, REM, 2'b00, 32'd100, 32'd7, r, vc, rb, ri);
      checks++; if (r !== 32'd2) begin errs++; $display("FAIL rem_unsigned: got %h expected 00000002", r); end
      run_op(1'b0, DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, vc, rb, ri);
      checks++; if (r !== 32'h8000_0000) begin errs++; $display("FAIL div_overflow: got %h expected 80000000", r); end
      run_op(1'b0, REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, vc, rb, ri);
      checks++; if (r !== 32'h0) begin errs++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
      // Mixed signedness on a division is unsigned: 0xFFFFFFF9 / 2
      run_op(1'b0, DIV, 2'b01, 32'hFFFF_FFF9, 32'h2, r, vc, rb, ri);
      checks++; if (r !== 32'h7FFF_FFFC) begin errs++; $display("FAIL div_mode01: got %h expected 7ffffffc", r); end
   endtask

   task automatic test_divzero();
      logic [31:0] r; int vc; bit rb, ri;
      run_op(1'b0, DIV, 2'b11, 32'h1234_5678, 32'h0, r, vc, rb, ri);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_div_early: got %h expected ffffffff", r); end
      checks++; if (vc !== 2) begin errs++; $display("FAIL dz_div_early_lat: got %0d expected 2", vc); end
      run_op(1'b0, REM, 2'b00, 32'h1234_5678, 32'h0, r, vc, rb, ri);
      checks++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL dz_rem_early: got %h expected 12345678", r); end
      checks++; if (vc !== 2) begin errs++; $display("FAIL dz_rem_early_lat: got %0d expected 2", vc); end
      run_op(1'b1, DIV, 2'b00, 32'h1234_5678, 32'h0, r, vc, rb, ri);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_div_full: got %h expected ffffffff", r); end
      checks++; if (vc !== 35) begin errs++; $display("FAIL dz_div_full_lat: got %0d expected 35", vc); end
      run_op(1'b1, REM, 2'b11, 32'h8765_4321, 32'h0, r, vc, rb, ri);
      checks++; if (r !== 32'h8765_4321) begin errs++; $display("FAIL dz_rem_full: got %h expected 87654321", r); end
      checks++; if (vc !== 35) begin errs++; $display("FAIL dz_rem_full_lat: got %0d expected 35", vc); end
   endtask

   task automatic test_kill();
      logic [31:0] prev; int seen, vc;
      prev = res0;
      @(negedge clk);
      op = MULL; mode = 2'b11; a = 32'h7; b = 32'hFFFF_FFFD; req0 = 1'b1;
      @(posedge clk); #1 req0 = 1'b0;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL kill_ready: got %b expected 1", rdy0); end
      checks++; if (vld0 !== 1'b0) begin errs++; $display("FAIL kill_valid: got %b expected 0", vld0); end
      checks++; if (res0 !== prev) begin errs++; $display("FAIL kill_result: got %h expected %h", res0, prev); end
      seen = 0;
      repeat (30) begin @(negedge clk); if (vld0) seen++; end
      checks++; if (seen !== 0) begin errs++; $display("FAIL kill_no_valid: got %0d strobes expected 0", seen); end
      // kill with a request in IDLE must not block the accept
      op = DIV; mode = 2'b00; a = 32'd100; b = 32'd7; req0 = 1'b1; kill = 1'b1;
      @(posedge clk); #1 req0 = 1'b0; kill = 1'b0;
      vc = 0;
      for (int c = 1; c <= 45 && vc == 0; c++) begin
         @(negedge clk);
         if (vld0) vc = c;
      end
      checks++; if (vc !== 35) begin errs++; $display("FAIL kill_idle_accept_lat: got %0d expected 35", vc); end
      checks++; if (res0 !== 32'd14) begin errs++; $display("FAIL kill_idle_accept_res: got %h expected 0000000e", res0); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      op = MULH; mode = 2'b00; a = 32'h8000_0000; b = 32'hFFFF_FFFF; req0 = 1'b1;
      @(posedge clk); #1 req0 = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
         errs++; $display("FAIL rst_mid_state: got rdy=%b vld=%b expected 1 0", rdy0, vld0); end
      checks++; if (res0 !== 32'h0) begin errs++; $display("FAIL rst_mid_result: got %h expected 00000000", res0); end
      seen = 0;
      repeat (30) begin @(negedge clk); if (vld0) seen++; end
      checks++; if (seen !== 0) begin errs++; $display("FAIL rst_mid_no_valid: got %0d strobes expected 0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int vc; bit rb, ri;
      run_op(1'b0, REM, 2'b00, 32'd100, 32'd7, r, vc, rb, ri);
      checks++; if (r !== 32'd2) begin errs++; $display("FAIL b2b_first: got %h expected 00000002", r); end
      run_op(1'b0, DIV, 2'b11, 32'hFFFF_FFF9, 32'h2, r, vc, rb, ri);
      checks++; if (ri !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b expected 1", ri); end
      checks++; if (vc !== 35) begin errs++; $display("FAIL b2b_latency: got %0d expected 35", vc); end
      checks++; if (r !== 32'hFFFF_FFFD) begin errs++; $display("FAIL b2b_second: got %h expected fffffffd", r); end
   endtask

   initial begin
      test_reset();
      test_mull();
      test_mulh();
      test_div();
      test_divzero();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
